// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared types and constants for the PS/2 keyboard link.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        WAIT_IDLE = 3'd4
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_BREAK    = 8'hF0;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_sync
//  Brief    : Two-flop synchronizers for the PS/2 clock/data lines and a
//             falling-edge strobe on the synchronized clock.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] r_clk_meta;
    logic [1:0] r_data_meta;
    logic       r_clk_prev;

    // Idle bus level is high, so flops come out of reset at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta  <= 2'b11;
            r_data_meta <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_meta  <= {r_clk_meta[0], ps2_clk_in};
            r_data_meta <= {r_data_meta[0], ps2_data_in};
            r_clk_prev  <= r_clk_meta[1];
        end
    end

    assign clk_sync  = r_clk_meta[1];
    assign data_sync = r_data_meta[1];
    assign clk_fall  = r_clk_prev & ~r_clk_meta[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Brief    : Host-to-device PS/2 command transmitter with ACK and timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       timeout
);

    localparam int                  c_CNT_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam int                  c_TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e         r_state;
    ps2_state_e         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TMR_W-1:0] r_timer;
    logic [3:0]         r_bitn;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic               r_data_bit;
    logic               r_nack;

    logic w_clk_sync;
    logic w_data_sync;
    logic w_clk_fall;
    logic w_accept;
    logic w_done;
    logic w_timeout;

    ps2_line_sync u_line_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (w_clk_sync),
        .data_sync   (w_data_sync),
        .clk_fall    (w_clk_fall)
    );

    assign w_accept  = tx_valid && (r_state == IDLE);
    assign w_done    = (r_state == WAIT_IDLE) && w_clk_sync && w_data_sync;
    // A completion on the final timer cycle takes priority over the abort.
    assign w_timeout = ((r_state == SEND) || (r_state == WAIT_IDLE)) &&
                       (r_timer == c_TMR_LAST) && !w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next_state = INHIBIT;
            INHIBIT:   if (r_cnt == '0) w_next_state = REQ;
            REQ:       w_next_state = SEND;
            SEND: begin
                if (w_timeout)                           w_next_state = IDLE;
                else if (w_clk_fall && r_bitn == 4'd10)  w_next_state = WAIT_IDLE;
            end
            WAIT_IDLE: if (w_done || w_timeout) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_ready    = 1'b0;
        busy        = 1'b1;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (r_state)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            INHIBIT: ps2_clk_oe = 1'b1;
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            SEND:    ps2_data_oe = r_data_bit;
            default: ;
        endcase
    end

    assign done    = w_done;
    assign nack    = w_done & r_nack;
    assign timeout = w_timeout;

    // Bit counter, shift data and timers; oe bit is pull-low, so it is the inverse of the line bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_timer    <= '0;
            r_bitn     <= 4'd0;
            r_shift    <= 8'h00;
            r_parity   <= 1'b0;
            r_data_bit <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= tx_data;
                        r_parity <= odd_parity(tx_data);
                        r_cnt    <= c_CNT_LOAD;
                    end
                end
                INHIBIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                REQ: begin
                    r_bitn     <= 4'd0;
                    r_timer    <= '0;
                    r_data_bit <= 1'b1;
                    r_nack     <= 1'b0;
                end
                SEND: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_clk_fall) begin
                        r_bitn <= r_bitn + 1'b1;
                        if (r_bitn < 4'd8)       r_data_bit <= ~r_shift[r_bitn[2:0]];
                        else if (r_bitn == 4'd8) r_data_bit <= ~r_parity;
                        else if (r_bitn == 4'd9) r_data_bit <= 1'b0;
                        else                     r_nack     <= w_data_sync;
                    end
                end
                WAIT_IDLE: r_timer <= r_timer + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Brief    : Directed and random transfers against a PS/2 device model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 5000;
    localparam int TMO     = 2000;
    localparam int HALF    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int to_cnt = 0;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .nack        (nack),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)    done_cnt++;
        if (timeout) to_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic exp_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic request(input logic [7:0] d, input bit pre, input bit hold, input logic [7:0] next_d);
        if (!pre) begin
            tx_valid = 1'b1;
            tx_data  = d;
            chk("ready_idle", tx_ready, 1);
        end
        cyc(1);
        chk("ready_drop", tx_ready, 0);
        chk("busy_set", busy, 1);
        if (hold) tx_data = next_d;
        else      tx_valid = 1'b0;
    endtask

    task automatic check_inhibit();
        int n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INHIBIT + 10) begin
            n++;
            cyc(1);
        end
        chk("inhibit_len", n, INHIBIT);
        chk("req_phase", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        cyc(1);
        chk("start_bit", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    // Device clocks the frame, sampling data just before each rising edge.
    task automatic device(input bit ack, input int abort_fall, output logic [9:0] frame);
        logic       sv_v;
        logic [7:0] sv_d;
        frame = '0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 2) begin
                sv_v = tx_valid;
                sv_d = tx_data;
                tx_valid = 1'b1;
                tx_data  = ~sv_d;
                cyc(1);
                chk("ready_while_busy", tx_ready, 0);
                cyc(1);
                tx_valid = sv_v;
                tx_data  = sv_d;
            end
            if (k == 11) begin
                dev_data_low = ack;
                cyc(3);
            end
            cyc(HALF);
            dev_clk_low = 1'b1;
            if (k == abort_fall) return;
            cyc(HALF);
            if (k <= 10) frame[k-1] = ps2_data_line;
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input bit exp_nack, input int d0);
        int n = 0;
        while (!done && n < 50) begin
            n++;
            cyc(1);
        end
        chk("done_seen", done, 1);
        chk("nack", nack, exp_nack);
        chk("ready_at_done", tx_ready, 0);
        cyc(1);
        chk("ready_after_done", tx_ready, 1);
        chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("done_once", done_cnt - d0, 1);
    endtask

    task automatic transfer(input logic [7:0] d, input bit ack, input bit pre,
                            input bit hold, input logic [7:0] next_d);
        logic [9:0] fr;
        int d0;
        d0 = done_cnt;
        request(d, pre, hold, next_d);
        check_inhibit();
        device(ack, 0, fr);
        chk("frame", fr, {1'b1, exp_parity(d), d});
        wait_done(!ack, d0);
    endtask

    initial begin
        logic [9:0] fr;
        int n, d0, t0;
        #1;
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("rst_pulses", {done, nack, timeout}, 3'b000);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        transfer(CMD_SET_LEDS, 1'b1, 1'b0, 1'b0, 8'h00);
        transfer(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        transfer(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
        transfer(8'h01, 1'b1, 1'b0, 1'b0, 8'h00);
        transfer(CMD_ECHO, 1'b0, 1'b0, 1'b0, 8'h00);

        // Device never clocks after release.
        d0 = done_cnt;
        t0 = to_cnt;
        request(CMD_RESET, 1'b0, 1'b0, 8'h00);
        check_inhibit();
        n = 0;
        while (!timeout && n < TMO + 10) begin
            n++;
            cyc(1);
        end
        chk("timeout_at", n, TMO - 1);
        chk("timeout_no_done", done, 0);
        cyc(1);
        chk("timeout_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("timeout_idle", tx_ready, 1);
        chk("timeout_once", to_cnt - t0, 1);
        chk("timeout_done_cnt", done_cnt - d0, 0);

        // Asynchronous reset after the fourth falling edge.
        request(8'h5A, 1'b0, 1'b0, 8'h00);
        check_inhibit();
        device(1'b1, 4, fr);
        cyc(5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("async_rst_ready", tx_ready, 1);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        transfer(CMD_ENABLE, 1'b1, 1'b0, 1'b0, 8'h00);

        // Back-to-back with tx_valid held high throughout.
        transfer(CMD_RESET, 1'b1, 1'b0, 1'b1, CMD_ENABLE);
        transfer(CMD_ENABLE, 1'b1, 1'b1, 1'b0, 8'h00);
        cyc(3);
        chk("b2b_idle_after", busy, 0);

        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            logic       a;
            d = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            transfer(d, a, 1'b0, 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs), 0xFF (reset) and 0xF4 (enable). It is the write side of the keyboard link; the existing receive driver remains the read side. It runs on the system clock, drives the open-drain PS/2 clock and data lines through active-high pull-low enables, and reports the device acknowledge.

Parameters:
INHIBIT_CYCLES, 5000, system clocks ps2_clk is held low before the start bit (≥100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, maximum system clocks from clock release to transfer completion (15 ms at 50 MHz)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
tx_valid  in  1  request to send tx_data
tx_data  in  8  command byte
tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid && tx_ready
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
ps2_data_in  in  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release
ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the transfer completes
nack  out  1  valid with done: 1 = device did not acknowledge
timeout  out  1  one-cycle pulse when a transfer is aborted by timeout

Behaviour:
- Line inputs: 2-flop synchronizer on each line. fall = synced clk was 1 on the previous cycle and is 0 now.
- Reset (asynchronous, any time including mid-transfer):
  - state=IDLE; both oe=0 (lines released).
  - done/nack/timeout=0; tx_ready=1; busy=0.
  - Counters cleared; synchronizer flops set to 1.
- IDLE:
  - On accept, latch shift = tx_data and parity = ~^tx_data (odd parity).
  - Load cnt = INHIBIT_CYCLES-1 and go to INHIBIT.
  - tx_valid while not in IDLE is ignored; nothing is queued.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0; cnt decrements each cycle.
  - At cnt=0, go to REQ.
- REQ (exactly 1 cycle):
  - ps2_clk_oe=1, ps2_data_oe=1.
  - Go to SEND with bitn=0 and timer=0.
- SEND:
  - ps2_clk_oe=0; ps2_data_oe holds the current bit (start bit = low).
  - timer increments every cycle.
  - On each fall, bitn increments and the output is updated:
    - bitn 0→1..7→8: data_oe = ~shift[bitn] (LSB first).
    - 8→9: data_oe = ~parity.
    - 9→10: data_oe=0 (stop bit released).
    - 10→11: sample synced data; nack = synced data (0 = ACK); go to WAIT_IDLE.
- WAIT_IDLE:
  - Both oe=0.
  - When synced clk=1 and synced data=1 on the same cycle: pulse done for 1 cycle with nack valid, then go to IDLE.
- Timeout:
  - Applies in SEND and WAIT_IDLE.
  - If timer reaches TIMEOUT_CYCLES-1 before done: release both lines, pulse timeout (done stays 0), go to IDLE.
  - If the timeout and a completion condition fall on the same cycle, completion wins.
- Falling edges seen in IDLE, INHIBIT or REQ are ignored.
- Latency:
  - tx_ready drops the cycle after accept.
  - Lines are released the cycle after done/timeout.
  - The next accept is possible the cycle after done.

Decomposition:
- Package ps2_pkg:
  - State enum (IDLE, INHIBIT, REQ, SEND, WAIT_IDLE).
  - Command constants: CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
  - Response constants: RSP_ACK=8'hFA, RSP_BREAK=8'hF0.
- One sub-module, ps2_line_sync: 2-flop synchronizer for clock and data plus falling-edge detect. It is reusable by a future clocked receive driver.

Test Plan:
- Send 0xED with an ACKing device model:
  - Clock is held low for exactly 5000 cycles, then data goes low one cycle before clock is released.
  - Device samples on rising edges 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - done pulses once with nack=0.
- Parity coverage with 0x00, 0xFF, 0x01 → parity bits 1, 1, 0; all complete with nack=0.
- NACK: device leaves data high on the 11th clock → done=1, nack=1, tx_ready returns high the next cycle.
- Timeout: device never clocks after release:
  - At timer = TIMEOUT_CYCLES-1, timeout pulses, done stays 0.
  - Both oe go to 0 the next cycle and the block returns to IDLE.
- Reset mid-transfer: assert rst_n=0 after the 4th falling edge → oe outputs go to 0 immediately (asynchronously); after release a new 0xF4 transfer completes normally.
- Back-to-back: tx_valid held high with 0xFF then 0xF4:
  - The second byte is accepted only in the cycle after the first done.
  - tx_valid pulses while busy have no effect.
